// File: rtl/lsu_mem_if.sv
// Load/store initiator between execute stage and byte-addressed data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu_mem_if #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [BITS-1:0] i_req_addr,
    input  logic [BITS-1:0] i_req_wdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [BITS-1:0] o_resp_rdata,
    output logic            o_resp_err,
    output logic [BITS-1:0] o_mem_ad,
    output logic            o_mem_we,
    output logic [2:0]      o_mem_b,
    inout  wire  [BITS-1:0] io_mem_rs
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ISSUE = 3'd1,
        S_LD_CAPT  = 3'd2,
        S_ST_ISSUE = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [BITS-1:0] r_resp_rdata;
    logic            r_resp_err;
    logic [BITS-1:0] r_mem_ad;
    logic            r_mem_we;
    logic [2:0]      r_mem_b;
    logic [BITS-1:0] r_wdata;
    logic            w_misalign;
    logic            w_illegal;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                      || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00))
                      || ((i_req_funct3[1:0] == 2'b11) && (i_req_addr[2:0] != 3'b000));
`else
    assign w_misalign = 1'b0;
`endif

    // 64-bit widths exist only on a 64-bit datapath; stores have no unsigned forms.
    assign w_illegal = (i_req_funct3 == 3'b111)
                     || ((BITS == 32'sd32) && ((i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110)))
                     || (i_req_we && i_req_funct3[2])
                     || w_misalign;

    // Bus is driven only while the registered write enable is high, so turnaround is clean.
    assign io_mem_rs = r_mem_we ? r_wdata : {BITS{1'bz}};

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_mem_ad     = r_mem_ad;
    assign o_mem_we     = r_mem_we;
    assign o_mem_b      = r_mem_b;

    // Request/response sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {BITS{1'b0}};
            r_resp_err   <= 1'b0;
            r_mem_ad     <= {BITS{1'b0}};
            r_mem_we     <= 1'b0;
            r_mem_b      <= 3'b000;
            r_wdata      <= {BITS{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_wdata     <= i_req_wdata;
                        if (w_illegal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= {BITS{1'b0}};
                        end else if (i_req_we) begin
                            r_state  <= S_ST_ISSUE;
                            r_mem_ad <= i_req_addr;
                            r_mem_b  <= i_req_funct3;
                            r_mem_we <= 1'b1;
                        end else begin
                            r_state  <= S_LD_ISSUE;
                            r_mem_ad <= i_req_addr;
                            r_mem_b  <= i_req_funct3;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_LD_ISSUE: begin
                    r_state <= S_LD_CAPT;
                end
                S_LD_CAPT: begin
                    r_state      <= S_RESP;
                    r_resp_rdata <= io_mem_rs;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                end
                S_ST_ISSUE: begin
                    r_state      <= S_RESP;
                    r_mem_we     <= 1'b0;
                    r_resp_rdata <= {BITS{1'b0}};
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if with a small byte-addressed memory model.
module tb_lsu_mem_if;
    localparam int BITS = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [BITS-1:0] req_addr, req_wdata;
    logic            resp_valid, resp_ready, resp_err;
    logic [BITS-1:0] resp_rdata, mem_ad;
    logic            mem_we;
    logic [2:0]      mem_b;
    wire  [BITS-1:0] mem_rs;

    logic [7:0]      mem [0:255];
    logic [BITS-1:0] rd_q;
    logic            mem_en;
    int              we_cnt = 0;
    int              checks = 0;
    int              errors = 0;
    int              lat;
    int              w0;

    lsu_mem_if #(.BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mem_ad(mem_ad), .o_mem_we(mem_we), .o_mem_b(mem_b), .io_mem_rs(mem_rs)
    );

    always #5 clk = ~clk;

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = acc_size(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem[a[7:0] + 8'(i)];
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Memory model: writes on mem_we, registers read data every edge.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < acc_size(mem_b); i++) mem[mem_ad[7:0] + 8'(i)] <= mem_rs[8*i +: 8];
            we_cnt <= we_cnt + 1;
        end
        rd_q <= mem_read(mem_ad, mem_b);
    end

    assign mem_rs = (mem_en && !mem_we) ? rd_q : {BITS{1'bz}};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        check_eq("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l);
        l = 0;
        while (!resp_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic take_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check_eq("hs_valid_low", 64'(resp_valid), 64'd0);
        check_eq("hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        accept(1'b0, f3, a, 32'h0);
        wait_resp(lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'd2);
        check_eq({tag, "_rdata"}, 64'(resp_rdata), 64'(exp));
        check_eq({tag, "_err"}, 64'(resp_err), 64'd0);
        take_resp();
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; mem_en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
        mem[8'h04] = 8'h80;
        mem[8'h20] = 8'h44; mem[8'h21] = 8'h33; mem[8'h22] = 8'h22; mem[8'h23] = 8'h11;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_rdata", 64'(resp_rdata), 64'd0);
        check_eq("rst_err", 64'(resp_err), 64'd0);
        check_eq("rst_mem_ad", 64'(mem_ad), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_b", 64'(mem_b), 64'd0);
        check_eq("rst_rs_z", 64'(mem_rs === {BITS{1'bz}}), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; mem_en = 1'b1;

        // LW 0x10 with issue-phase address/width
        accept(1'b0, 3'b010, 32'h10, 32'h0);
        check_eq("lw_mem_ad", 64'(mem_ad), 64'h10);
        check_eq("lw_mem_b", 64'(mem_b), 64'd2);
        check_eq("lw_mem_we", 64'(mem_we), 64'd0);
        wait_resp(lat);
        check_eq("lw_lat", 64'(lat), 64'd2);
        check_eq("lw_rdata", 64'(resp_rdata), 64'hDEADBEEF);
        check_eq("lw_err", 64'(resp_err), 64'd0);
        take_resp();

        do_load("lb", 3'b000, 32'h04, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h04, 32'h00000080);

        // SH over a preloaded word
        w0 = we_cnt;
        accept(1'b1, 3'b001, 32'h20, 32'h1234ABCD);
        check_eq("sh_mem_we", 64'(mem_we), 64'd1);
        check_eq("sh_mem_rs", 64'(mem_rs), 64'h1234ABCD);
        check_eq("sh_mem_b", 64'(mem_b), 64'd1);
        wait_resp(lat);
        check_eq("sh_lat", 64'(lat), 64'd1);
        check_eq("sh_we_fall", 64'(mem_we), 64'd0);
        check_eq("sh_rdata", 64'(resp_rdata), 64'd0);
        check_eq("sh_err", 64'(resp_err), 64'd0);
        take_resp();
        check_eq("sh_we_cycles", 64'(we_cnt - w0), 64'd1);
        do_load("lw_after_sh", 3'b010, 32'h20, 32'h1122ABCD);

        // LW at a misaligned address
        w0 = we_cnt;
        accept(1'b0, 3'b010, 32'h22, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        wait_resp(lat);
        check_eq("mis_lat", 64'(lat), 64'd0);
        check_eq("mis_err", 64'(resp_err), 64'd1);
        check_eq("mis_rdata", 64'(resp_rdata), 64'd0);
        check_eq("mis_mem_ad", 64'(mem_ad), 64'h20);
`else
        check_eq("mis_mem_ad", 64'(mem_ad), 64'h22);
        wait_resp(lat);
        check_eq("mis_lat", 64'(lat), 64'd2);
        check_eq("mis_err", 64'(resp_err), 64'd0);
        check_eq("mis_rdata", 64'(resp_rdata), 64'h00001122);
`endif
        take_resp();
        check_eq("mis_no_write", 64'(we_cnt - w0), 64'd0);

        // LD on a 32-bit datapath, then back-pressure
        w0 = we_cnt;
        accept(1'b0, 3'b011, 32'h40, 32'h0);
        wait_resp(lat);
        check_eq("ld_lat", 64'(lat), 64'd0);
        check_eq("ld_err", 64'(resp_err), 64'd1);
        check_eq("ld_rdata", 64'(resp_rdata), 64'd0);
        check_eq("ld_mem_b", 64'(mem_b), 64'd2);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("ld_mem_ad", 64'(mem_ad), 64'h20);
`else
        check_eq("ld_mem_ad", 64'(mem_ad), 64'h22);
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(resp_valid), 64'd1);
            check_eq("hold_err", 64'(resp_err), 64'd1);
            check_eq("hold_rdata", 64'(resp_rdata), 64'd0);
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        take_resp();
        check_eq("ld_no_write", 64'(we_cnt - w0), 64'd0);

        // Store with an unsigned width code
        w0 = we_cnt;
        accept(1'b1, 3'b100, 32'h30, 32'hFF);
        wait_resp(lat);
        check_eq("sbu_lat", 64'(lat), 64'd0);
        check_eq("sbu_err", 64'(resp_err), 64'd1);
        take_resp();
        check_eq("sbu_no_write", 64'(we_cnt - w0), 64'd0);

        // Reset in LD_CAPT, with the memory driver released to expose the DUT's driver
        accept(1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk);
        #1 mem_en = 1'b0; rst_n = 1'b0;
        #2;
        check_eq("rcap_valid", 64'(resp_valid), 64'd0);
        check_eq("rcap_req_ready", 64'(req_ready), 64'd1);
        check_eq("rcap_mem_we", 64'(mem_we), 64'd0);
        check_eq("rcap_rs_z", 64'(mem_rs === {BITS{1'bz}}), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; mem_en = 1'b1;
        do_load("lw_post_rst", 3'b010, 32'h10, 32'hDEADBEEF);

        // Reset in ST_ISSUE: the store must not land
        accept(1'b1, 3'b000, 32'h30, 32'h5A);
        check_eq("rst_st_we_hi", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_st_we_lo", 64'(mem_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load("lbu_aborted", 3'b100, 32'h30, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
